// File: rtl/udp_fragment_slot.sv
// One IPv4 fragment reassembly slot: captures the bytes steered to it, owns a packet ID,
// and drains the completed datagram over a valid/ready byte stream. Stalled or overflowing fills are discarded.
module udp_fragment_slot #(
  parameter int          DEPTH       = 2048,
  parameter logic [15:0] STALE_LIMIT = 16'd4096
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [7:0]                 push_data,
  input  logic                       push_data_valid,
  input  logic                       push_data_last,
  input  logic [15:0]                packet_id,
  output logic                       slot_empty,
  output logic [15:0]                slot_packet_id,
  output logic [7:0]                 pop_data,
  output logic                       pop_valid,
  output logic                       pop_last,
  input  logic                       pop_ready,
  output logic [$clog2(DEPTH):0]     byte_count,
  output logic                       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_DISCARD = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [15:0]    stale_q, stale_d;
  logic [15:0]    stale_inc;
  logic [15:0]    pid_q, pid_d;
  logic [7:0]     pop_data_q, pop_data_d;
  logic           pop_valid_q, pop_valid_d;
  logic           pop_last_q, pop_last_d;
  logic           dropped_q, dropped_d;
  logic           slot_empty_q, slot_empty_d;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     rd_data;
  logic [7:0]     mem [DEPTH];

  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  // Storage write port; contents are don't-care outside a fill.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= push_data;
    end
  end

  // Next-state, storage control and output computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    stale_d     = 16'd0;
    pid_d       = pid_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = pop_valid_q;
    pop_last_d  = pop_last_q;
    dropped_d   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = count_q[AW-1:0];
    stale_inc   = stale_q + 16'd1;

    case (state_q)
      S_EMPTY: begin
        count_d = ZERO_C;
        if (push_data_valid) begin
          wr_en   = 1'b1;
          wr_addr = {AW{1'b0}};
          pid_d   = packet_id;
          count_d = ONE_C;
          state_d = push_data_last ? S_DRAIN : S_FILLING;
        end else begin
          state_d = S_EMPTY;
        end
      end

      S_FILLING: begin
        if (push_data_valid && (count_q == DEPTH_C)) begin
          // Overflowing byte is never stored; a coincident last closes the discard at once.
          dropped_d = 1'b1;
          if (push_data_last) begin
            state_d = S_EMPTY;
            count_d = ZERO_C;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (push_data_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + ONE_C;
          state_d = push_data_last ? S_DRAIN : S_FILLING;
        end else if (push_data_last) begin
          state_d = S_DRAIN;
        end else if (stale_inc == STALE_LIMIT) begin
          dropped_d = 1'b1;
          state_d   = S_EMPTY;
          count_d   = ZERO_C;
        end else begin
          stale_d = stale_inc;
        end
      end

      S_DISCARD: begin
        if (push_data_last) begin
          state_d = S_EMPTY;
          count_d = ZERO_C;
        end else if (push_data_valid) begin
          stale_d = 16'd0;
        end else if (stale_inc == STALE_LIMIT) begin
          state_d = S_EMPTY;
          count_d = ZERO_C;
        end else begin
          stale_d = stale_inc;
        end
      end

      S_DRAIN: begin
        dropped_d = push_data_valid;
        if (pop_valid_q && pop_ready && pop_last_q) begin
          state_d     = S_EMPTY;
          count_d     = ZERO_C;
          rd_ptr_d    = ZERO_C;
          pop_valid_d = 1'b0;
          pop_last_d  = 1'b0;
          pop_data_d  = 8'd0;
        end else if (!pop_valid_q || pop_ready) begin
          // Prefetch the next byte into the output register so transfers run back to back.
          pop_data_d  = rd_data;
          pop_valid_d = 1'b1;
          pop_last_d  = (rd_ptr_q == (count_q - ONE_C));
          rd_ptr_d    = rd_ptr_q + ONE_C;
        end else begin
          pop_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_EMPTY;
        count_d = ZERO_C;
      end
    endcase

    slot_empty_d = (state_d == S_EMPTY);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_EMPTY;
      count_q      <= ZERO_C;
      rd_ptr_q     <= ZERO_C;
      stale_q      <= 16'd0;
      pid_q        <= 16'd0;
      pop_data_q   <= 8'd0;
      pop_valid_q  <= 1'b0;
      pop_last_q   <= 1'b0;
      dropped_q    <= 1'b0;
      slot_empty_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      stale_q      <= stale_d;
      pid_q        <= pid_d;
      pop_data_q   <= pop_data_d;
      pop_valid_q  <= pop_valid_d;
      pop_last_q   <= pop_last_d;
      dropped_q    <= dropped_d;
      slot_empty_q <= slot_empty_d;
    end
  end

  assign slot_empty     = slot_empty_q;
  assign slot_packet_id = pid_q;
  assign pop_data       = pop_data_q;
  assign pop_valid      = pop_valid_q;
  assign pop_last       = pop_last_q;
  assign byte_count     = count_q;
  assign dropped        = dropped_q;

endmodule

// File: tb/tb_udp_fragment_slot.sv
// Self-checking bench for udp_fragment_slot: directed scenarios plus randomized datagrams
// compared against byte queues built by the bench.
module tb_udp_fragment_slot;

  localparam int          DEPTH = 16;
  localparam logic [15:0] STALE = 16'd40;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset_n;
  logic [7:0]    push_data;
  logic          push_data_valid;
  logic          push_data_last;
  logic [15:0]   packet_id;
  logic          slot_empty;
  logic [15:0]   slot_packet_id;
  logic [7:0]    pop_data;
  logic          pop_valid;
  logic          pop_last;
  logic          pop_ready;
  logic [CW-1:0] byte_count;
  logic          dropped;

  udp_fragment_slot #(.DEPTH(DEPTH), .STALE_LIMIT(STALE)) dut (
    .clock(clock), .reset_n(reset_n),
    .push_data(push_data), .push_data_valid(push_data_valid), .push_data_last(push_data_last),
    .packet_id(packet_id), .slot_empty(slot_empty), .slot_packet_id(slot_packet_id),
    .pop_data(pop_data), .pop_valid(pop_valid), .pop_last(pop_last), .pop_ready(pop_ready),
    .byte_count(byte_count), .dropped(dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt = 0;
  logic [7:0] got_data[$];
  bit         got_last[$];
  int         got_cycles;
  int         got_unstable;
  bit         got_timeout;

  task automatic tick();
    @(posedge clock);
    #1;
    if (dropped === 1'b1) drop_cnt++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; push_data_valid = 1'b0; push_data_last = 1'b0;
    push_data = 8'd0; packet_id = 16'd0; pop_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    drop_cnt = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic [15:0] pid, input bit last);
    push_data = d; packet_id = pid; push_data_valid = 1'b1; push_data_last = last;
    tick();
    push_data_valid = 1'b0; push_data_last = 1'b0;
  endtask

  task automatic push_last_only();
    push_data_last = 1'b1;
    tick();
    push_data_last = 1'b0;
  endtask

  // Consumer: mode 0 always ready, 1 toggles per valid cycle starting low, 2 random.
  task automatic collect(input int mode, input int budget);
    bit tog = 1'b0;
    bit prev_stall = 1'b0;
    bit done = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic prev_l = 1'b0;
    int n = 0;
    got_data.delete(); got_last.delete();
    got_cycles = 0; got_unstable = 0; got_timeout = 1'b0;
    while (!done && n < budget) begin
      n++;
      if (pop_valid === 1'b1) begin
        case (mode)
          0:       pop_ready = 1'b1;
          1:       pop_ready = tog;
          default: pop_ready = 1'($urandom_range(0, 1));
        endcase
        got_cycles++;
        if (prev_stall && ((pop_data !== prev_d) || (pop_last !== prev_l))) got_unstable++;
        if (pop_ready) begin
          got_data.push_back(pop_data);
          got_last.push_back(pop_last === 1'b1);
          if (pop_last === 1'b1) done = 1'b1;
        end
        prev_stall = !pop_ready; prev_d = pop_data; prev_l = pop_last; tog = ~tog;
      end else begin
        pop_ready = 1'b0; prev_stall = 1'b0;
      end
      tick();
    end
    pop_ready = 1'b0;
    got_timeout = !done;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({slot_empty, pop_valid, pop_last, dropped} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got empty/valid/last/drop=%b want 1000", {slot_empty, pop_valid, pop_last, dropped});
    end
    n_tests++;
    if ({slot_packet_id, pop_data} !== 24'd0) begin
      n_fail++; $display("FAIL reset_data: got pid=%h data=%h want 0", slot_packet_id, pop_data);
    end
    n_tests++;
    if (byte_count !== CW'(0)) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", byte_count);
    end
  endtask

  task automatic test_basic();
    int errs = 0;
    push(8'd0, 16'h1234, 1'b0);
    n_tests++;
    if (slot_empty !== 1'b0 || slot_packet_id !== 16'h1234 || byte_count !== CW'(1)) begin
      n_fail++; $display("FAIL basic_first: empty=%b pid=%h cnt=%0d want 0/1234/1", slot_empty, slot_packet_id, byte_count);
    end
    for (int i = 1; i < 10; i++) push(8'(i), 16'hFFFF, 1'b0);
    n_tests++;
    if (byte_count !== CW'(10) || slot_packet_id !== 16'h1234) begin
      n_fail++; $display("FAIL basic_fill: cnt=%0d pid=%h want 10/1234", byte_count, slot_packet_id);
    end
    push_last_only();
    n_tests++;
    if (pop_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency1: pop_valid=%b want 0", pop_valid);
    end
    tick();
    n_tests++;
    if (pop_valid !== 1'b1 || pop_data !== 8'd0) begin
      n_fail++; $display("FAIL basic_latency2: pop_valid=%b data=%h want 1/00", pop_valid, pop_data);
    end
    collect(0, 50);
    if (got_data.size() != 10) errs++;
    else for (int i = 0; i < 10; i++) if (got_data[i] !== 8'(i) || got_last[i] != (i == 9)) errs++;
    n_tests++;
    if (errs != 0 || got_timeout || got_cycles != 10) begin
      n_fail++; $display("FAIL basic_drain: bytes=%0d bad=%0d cycles=%0d timeout=%0d want 10/0/10/0", got_data.size(), errs, got_cycles, got_timeout);
    end
    n_tests++;
    if (slot_empty !== 1'b1 || byte_count !== CW'(0)) begin
      n_fail++; $display("FAIL basic_free: empty=%b cnt=%0d want 1/0", slot_empty, byte_count);
    end
  endtask

  task automatic test_stall();
    int errs = 0;
    for (int i = 0; i < 10; i++) push(8'(i), 16'hBEEF, i == 9);
    collect(1, 100);
    if (got_data.size() != 10) errs++;
    else for (int i = 0; i < 10; i++) if (got_data[i] !== 8'(i) || got_last[i] != (i == 9)) errs++;
    n_tests++;
    if (errs != 0 || got_timeout || got_unstable != 0 || got_cycles != 20) begin
      n_fail++; $display("FAIL stall_drain: bytes=%0d bad=%0d unstable=%0d cycles=%0d want 10/0/0/20", got_data.size(), errs, got_unstable, got_cycles);
    end
  endtask

  task automatic test_overflow();
    int seen_valid = 0;
    drop_cnt = 0;
    for (int i = 0; i < DEPTH; i++) push(8'(i + 100), 16'h0F0F, 1'b0);
    n_tests++;
    if (drop_cnt != 0 || byte_count !== CW'(DEPTH)) begin
      n_fail++; $display("FAIL ovf_full: drops=%0d cnt=%0d want 0/%0d", drop_cnt, byte_count, DEPTH);
    end
    push(8'hEE, 16'h0F0F, 1'b0);
    n_tests++;
    if (drop_cnt != 1 || slot_empty !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drop: drops=%0d empty=%b want 1/0", drop_cnt, slot_empty);
    end
    push_last_only();
    for (int i = 0; i < 5; i++) begin
      if (pop_valid === 1'b1) seen_valid++;
      tick();
    end
    n_tests++;
    if (seen_valid != 0 || slot_empty !== 1'b1 || byte_count !== CW'(0) || drop_cnt != 1) begin
      n_fail++; $display("FAIL ovf_after: valid_cycles=%0d empty=%b cnt=%0d drops=%0d want 0/1/0/1", seen_valid, slot_empty, byte_count, drop_cnt);
    end
  endtask

  task automatic test_stale();
    for (int i = 0; i < 3; i++) push(8'(i), 16'h5151, 1'b0);
    drop_cnt = 0;
    repeat (int'(STALE) - 1) tick();
    n_tests++;
    if (drop_cnt != 0 || slot_empty !== 1'b0 || byte_count !== CW'(3)) begin
      n_fail++; $display("FAIL stale_early: drops=%0d empty=%b cnt=%0d want 0/0/3", drop_cnt, slot_empty, byte_count);
    end
    tick();
    n_tests++;
    if (drop_cnt != 1 || slot_empty !== 1'b1 || byte_count !== CW'(0)) begin
      n_fail++; $display("FAIL stale_expire: drops=%0d empty=%b cnt=%0d want 1/1/0", drop_cnt, slot_empty, byte_count);
    end
    repeat (3) tick();
    n_tests++;
    if (drop_cnt != 1) begin
      n_fail++; $display("FAIL stale_once: drops=%0d want 1", drop_cnt);
    end
  endtask

  task automatic test_single();
    drop_cnt = 0;
    push(8'hA5, 16'h7777, 1'b1);
    push(8'h11, 16'h9999, 1'b0);
    n_tests++;
    if (drop_cnt != 1 || slot_packet_id !== 16'h7777) begin
      n_fail++; $display("FAIL single_push_in_drain: drops=%0d pid=%h want 1/7777", drop_cnt, slot_packet_id);
    end
    collect(0, 20);
    n_tests++;
    if (got_timeout || got_data.size() != 1 || got_cycles != 1) begin
      n_fail++; $display("FAIL single_drain: bytes=%0d cycles=%0d timeout=%0d want 1/1/0", got_data.size(), got_cycles, got_timeout);
    end else if (got_data[0] !== 8'hA5 || !got_last[0]) begin
      n_fail++; $display("FAIL single_byte: got %h last=%0d want a5/1", got_data[0], got_last[0]);
    end
    n_tests++;
    if (slot_empty !== 1'b1 || drop_cnt != 1) begin
      n_fail++; $display("FAIL single_free: empty=%b drops=%0d want 1/1", slot_empty, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 5; i++) push(8'(i + 1), 16'hCAFE, i == 4);
    tick();
    pop_ready = 1'b1;
    tick();
    drop_cnt = 0;
    reset_n = 1'b0;
    tick();
    n_tests++;
    if ({slot_empty, pop_valid, pop_last, dropped} !== 4'b1000 || slot_packet_id !== 16'd0
        || pop_data !== 8'd0 || byte_count !== CW'(0) || drop_cnt != 0) begin
      n_fail++; $display("FAIL reset_drain: flags=%b pid=%h data=%h cnt=%0d drops=%0d want 1000/0/0/0/0",
                         {slot_empty, pop_valid, pop_last, dropped}, slot_packet_id, pop_data, byte_count, drop_cnt);
    end
    reset_n = 1'b1; pop_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (pop_valid !== 1'b0 || slot_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_drain_after: valid=%b empty=%b want 0/1", pop_valid, slot_empty);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int len = $urandom_range(1, DEPTH + 2);
      logic [15:0] pid = 16'($urandom);
      bit last_sep = (len > DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      logic [7:0] exp_q[$];
      int errs = 0;
      drop_cnt = 0;
      for (int i = 0; i < len; i++) begin
        logic [7:0] b = 8'($urandom);
        if (i < DEPTH) exp_q.push_back(b);
        push(b, (i == 0) ? pid : 16'($urandom), (i == len - 1) && !last_sep);
        if (i == 0 && slot_packet_id !== pid) errs++;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) tick();
      end
      if (last_sep) push_last_only();
      if (len <= DEPTH) begin
        collect(2, 400);
        if (got_data.size() != exp_q.size()) errs++;
        else for (int i = 0; i < exp_q.size(); i++)
          if (got_data[i] !== exp_q[i] || got_last[i] != (i == exp_q.size() - 1)) errs++;
        n_tests++;
        if (errs != 0 || got_timeout || got_unstable != 0 || drop_cnt != 0 || slot_empty !== 1'b1) begin
          n_fail++; $display("FAIL rand_drain[%0d]: len=%0d got=%0d bad=%0d unstable=%0d drops=%0d empty=%b timeout=%0d",
                             it, len, got_data.size(), errs, got_unstable, drop_cnt, slot_empty, got_timeout);
        end
      end else begin
        tick();
        n_tests++;
        if (errs != 0 || drop_cnt != 1 || slot_empty !== 1'b1 || pop_valid !== 1'b0) begin
          n_fail++; $display("FAIL rand_ovf[%0d]: len=%0d bad=%0d drops=%0d empty=%b valid=%b want 0/1/1/0",
                             it, len, errs, drop_cnt, slot_empty, pop_valid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_stale();
    test_single();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/udp_fragment_slot.md
# udp_fragment_slot

Single IPv4 fragment reassembly slot for the UDP receive path: one instance per fragment slot, downstream of the UDP receive handler. Captures the byte stream steered to this slot, latches the owning packet ID, and reports empty/packet-ID status back so the handler can pick a free or matching slot. On completion it drains the reassembled datagram to the consumer over a valid/ready byte stream, then frees itself. Stalled or overflowing fills are discarded.

## Interface
- DEPTH, 2048, slot byte capacity; power of two, ≥ 2
- STALE_LIMIT, 16'd4096, idle cycles in a fill before the slot is discarded; nonzero
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- push_data  in  8  byte from the receive handler
- push_data_valid  in  1  this slot's bit of the handler's push_data_valid
- push_data_last  in  1  this slot's bit of push_data_last; datagram complete
- packet_id  in  16  IPv4 identification from the handler
- slot_empty  out  1  slot free; feeds fragment_slot_empty
- slot_packet_id  out  16  owning packet ID; feeds fragment_slot_packet_id
- pop_data  out  8  reassembled byte
- pop_valid  out  1  pop_data valid
- pop_last  out  1  final byte of datagram, qualified by pop_valid
- pop_ready  in  1  consumer accepts byte
- byte_count  out  $clog2(DEPTH)+1  bytes currently stored
- dropped  out  1  one-cycle pulse: fill discarded or push rejected

## Operation
- States: S_EMPTY, S_FILLING, S_DISCARD, S_DRAIN.
- S_EMPTY: slot_empty=1. push_data_valid writes byte at address 0, latches packet_id into slot_packet_id, byte_count=1, → S_FILLING. push_data_last alone is ignored (no zero-length datagrams). If valid and last in the same cycle: write byte, → S_DRAIN.
- S_FILLING: each push_data_valid writes at address byte_count, increments byte_count, reloads stale counter. push_data_last → S_DRAIN (a byte valid in the same cycle is written first). packet_id is not re-latched.
- Overflow: push_data_valid with byte_count==DEPTH → pulse dropped, → S_DISCARD; byte not stored.
- Stale: stale counter reaches STALE_LIMIT with no push → pulse dropped, → S_EMPTY, byte_count=0.
- S_DISCARD: slot_empty=0, pushes ignored; push_data_last or stale expiry → S_EMPTY, byte_count=0.
- S_DRAIN: read pointer from 0; pop_valid held until last byte transferred. Transfer when pop_valid && pop_ready. pop_last=1 while read pointer == byte_count-1. After last transfer → S_EMPTY, byte_count=0, read pointer=0.
- push_data_valid while in S_DRAIN: ignored, dropped pulsed.
- slot_packet_id holds last latched value outside S_EMPTY; it is only meaningful when slot_empty=0.
- Write address, read pointer and byte_count never wrap; DEPTH bound is checked before write.

## Timing
- Reset (reset_n low at a clock edge): state S_EMPTY, slot_empty=1, slot_packet_id=0, pop_valid=0, pop_last=0, pop_data=0, byte_count=0, dropped=0, stale counter=0. Reset mid-fill or mid-drain discards contents with no dropped pulse.
- slot_empty, byte_count, slot_packet_id registered: change the cycle after the triggering push.
- push_data_last at edge N → S_DRAIN from N+1; storage read is one cycle latency, so pop_valid first high at N+2.
- Sustained throughput one byte per cycle while pop_ready=1; pop_data/pop_last stable while pop_valid && !pop_ready.
- Last transfer at edge M → slot_empty=1 from M+1; a push at M+1 starts a new fill.
- Stale counter counts every cycle in S_FILLING/S_DISCARD without a push; expiry at count==STALE_LIMIT.

## Test plan
- Push 10 bytes 0x00..0x09 with packet_id 0x1234, last after byte 9, pop_ready=1 → slot_empty falls after first byte, slot_packet_id=0x1234, pop_valid 2 cycles after last, 10 bytes in order, pop_last on 0x09, slot_empty=1 next cycle.
- Same 10-byte drain with pop_ready toggling 1/0 each cycle → identical byte sequence, data stable while stalled, 20-cycle drain.
- DEPTH=16, push 17 bytes then last → dropped pulse on 17th, no pop_valid, slot_empty=1 after last.
- Push 3 bytes then idle STALE_LIMIT cycles → one dropped pulse, byte_count=0, slot_empty=1.
- Single byte with valid and last same cycle → one pop byte with pop_last=1; push during drain → dropped pulse, drain unaffected.
- reset_n low mid-drain → all outputs at reset values next cycle, no dropped pulse.
